// File: rtl/op_centric_deque.sv
// ---------------------------------------------------------------------------
// op_centric_deque
//
// Double-ended queue built on one shift-register storage array, where entry 0
// is always the front. Four operation interfaces (push_back, push_front,
// pop_front, pop_back) use valid/ready handshakes. An operation fires when its
// en and rdy are both high. A small control unit turns the fired operations
// into one decoded op, then into a per-entry source select
// (hold / shift up / shift down / front data / back data).
//
// Parameters:
//   p_depth     number of entries (>= 2)
//   p_bitwidth  data width of each entry
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   push_back_en/rdy/data            append at tail
//   push_front_en/rdy/data           insert at head
//   pop_front_en/rdy, pop_front_data remove head; data = entry[0]
//   pop_back_en/rdy,  pop_back_data  remove tail; data = entry[count-1]
//   count                            current occupancy
// ---------------------------------------------------------------------------
module op_centric_deque #(
   parameter int unsigned p_depth    = 32,
   parameter int unsigned p_bitwidth = 32,
   localparam int unsigned CountW    = $clog2(p_depth + 1)
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  push_back_en,
   output logic                  push_back_rdy,
   input  logic [p_bitwidth-1:0] push_back_data,

   input  logic                  push_front_en,
   output logic                  push_front_rdy,
   input  logic [p_bitwidth-1:0] push_front_data,

   input  logic                  pop_front_en,
   output logic                  pop_front_rdy,
   output logic [p_bitwidth-1:0] pop_front_data,

   input  logic                  pop_back_en,
   output logic                  pop_back_rdy,
   output logic [p_bitwidth-1:0] pop_back_data,

   output logic [CountW-1:0]     count
);

   localparam logic [CountW-1:0] DepthC = CountW'(p_depth);
   localparam logic [CountW-1:0] OneC   = CountW'(1);

   // Decoded combination of fired operations.
   typedef enum logic [3:0] {
      OpNone,
      OpPushBack,
      OpPushFront,
      OpPopFront,
      OpPopBack,
      OpPushBackPopFront,
      OpPushBackPopBack,
      OpPushFrontPopFront,
      OpPushFrontPopBack
   } op_e;

   // Per-entry next-value source.
   typedef enum logic [2:0] {
      SelHold,
      SelUp,
      SelDown,
      SelFront,
      SelBack
   } sel_e;

   logic [p_bitwidth-1:0] entry_q [p_depth];
   logic [p_bitwidth-1:0] entry_d [p_depth];
   logic [p_bitwidth-1:0] up_src  [p_depth];
   logic [p_bitwidth-1:0] down_src[p_depth];
   sel_e                  sel     [p_depth];
   logic [CountW-1:0]     count_q, count_d;

   logic      not_full, not_empty;
   logic      push_back_fire, push_front_fire, pop_front_fire, pop_back_fire;
   logic      push_fire, pop_fire;
   logic [CountW-1:0] back_idx;
   op_e       op;

   // -------------------------------------------------------------------------
   // Handshakes: all readiness comes from the registered count, no bypass.
   // -------------------------------------------------------------------------
   always_comb begin
      not_full  = (count_q < DepthC);
      not_empty = (count_q != '0);

      push_front_rdy = !rst && not_full;
      push_back_rdy  = !rst && not_full && !push_front_en;
      pop_front_rdy  = !rst && not_empty;
      pop_back_rdy   = !rst && not_empty && !pop_front_en;

      push_back_fire  = push_back_en  && push_back_rdy;
      push_front_fire = push_front_en && push_front_rdy;
      pop_front_fire  = pop_front_en  && pop_front_rdy;
      pop_back_fire   = pop_back_en   && pop_back_rdy;

      push_fire = push_back_fire || push_front_fire;
      pop_fire  = pop_front_fire || pop_back_fire;
   end

   // -------------------------------------------------------------------------
   // Control unit: decode the fired operations into a single op.
   // The ready rules guarantee at most one push and one pop.
   // -------------------------------------------------------------------------
   always_comb begin
      op = OpNone;
      if (push_back_fire) begin
         if (pop_front_fire)     op = OpPushBackPopFront;
         else if (pop_back_fire) op = OpPushBackPopBack;
         else                    op = OpPushBack;
      end else if (push_front_fire) begin
         if (pop_front_fire)     op = OpPushFrontPopFront;
         else if (pop_back_fire) op = OpPushFrontPopBack;
         else                    op = OpPushFront;
      end else if (pop_front_fire) begin
         op = OpPopFront;
      end else if (pop_back_fire) begin
         op = OpPopBack;
      end
   end

   // Tail write slot: the free slot after the tail, or the old tail slot when a
   // pop in the same cycle frees it (pop_fire implies count_q > 0).
   always_comb begin
      back_idx = pop_fire ? (count_q - OneC) : count_q;
   end

   // Per-entry select generation.
   always_comb begin
      for (int i = 0; i < p_depth; i++) begin
         sel[i] = SelHold;
      end
      unique case (op)
         OpPushBack, OpPushBackPopBack: begin
            for (int i = 0; i < p_depth; i++) begin
               if (CountW'(i) == back_idx) sel[i] = SelBack;
            end
         end
         OpPushFront, OpPushFrontPopBack: begin
            // Entries past the tail shift too; they are don't-care.
            sel[0] = SelFront;
            for (int i = 1; i < p_depth; i++) begin
               sel[i] = SelUp;
            end
         end
         OpPopFront: begin
            for (int i = 0; i < p_depth - 1; i++) begin
               sel[i] = SelDown;
            end
         end
         OpPushBackPopFront: begin
            // Shift down, then the vacated tail slot takes the new data.
            for (int i = 0; i < p_depth - 1; i++) begin
               sel[i] = SelDown;
            end
            for (int i = 0; i < p_depth; i++) begin
               if (CountW'(i) == back_idx) sel[i] = SelBack;
            end
         end
         OpPushFrontPopFront: begin
            sel[0] = SelFront;
         end
         OpPopBack, OpNone: begin
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: neighbour sources and per-entry next value.
   // -------------------------------------------------------------------------
   always_comb begin
      up_src[0] = entry_q[0];
      for (int i = 1; i < p_depth; i++) begin
         up_src[i] = entry_q[i-1];
      end
      down_src[p_depth-1] = entry_q[p_depth-1];
      for (int i = 0; i < p_depth - 1; i++) begin
         down_src[i] = entry_q[i+1];
      end
   end

   always_comb begin
      for (int i = 0; i < p_depth; i++) begin
         entry_d[i] = entry_q[i];
         unique case (sel[i])
            SelUp:    entry_d[i] = up_src[i];
            SelDown:  entry_d[i] = down_src[i];
            SelFront: entry_d[i] = push_front_data;
            SelBack:  entry_d[i] = push_back_data;
            default:  entry_d[i] = entry_q[i];
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (push_fire && !pop_fire) count_d = count_q + OneC;
      else if (pop_fire && !push_fire) count_d = count_q - OneC;
   end

   // -------------------------------------------------------------------------
   // State. Entry contents need no reset; only the occupancy matters.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < p_depth; i++) begin
         entry_q[i] <= entry_d[i];
      end
   end

   // -------------------------------------------------------------------------
   // Read side: combinational from storage, zero when empty.
   // -------------------------------------------------------------------------
   always_comb begin
      pop_front_data = not_empty ? entry_q[0] : '0;
      pop_back_data  = '0;
      for (int i = 0; i < p_depth; i++) begin
         if (not_empty && (CountW'(i) == count_q - OneC)) pop_back_data = entry_q[i];
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_op_centric_deque.sv
// ---------------------------------------------------------------------------
// Directed bench for op_centric_deque with a small depth so the full and
// single-entry boundaries are reached quickly.
// ---------------------------------------------------------------------------
module tb_op_centric_deque;

   localparam int unsigned Depth = 4;
   localparam int unsigned Width = 8;
   localparam int unsigned CW    = $clog2(Depth + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             push_back_en, push_front_en, pop_front_en, pop_back_en;
   logic             push_back_rdy, push_front_rdy, pop_front_rdy, pop_back_rdy;
   logic [Width-1:0] push_back_data, push_front_data;
   logic [Width-1:0] pop_front_data, pop_back_data;
   logic [CW-1:0]    count;

   int n_checks = 0;
   int n_fails  = 0;

   op_centric_deque #(
      .p_depth    (Depth),
      .p_bitwidth (Width)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .push_back_en    (push_back_en),
      .push_back_rdy   (push_back_rdy),
      .push_back_data  (push_back_data),
      .push_front_en   (push_front_en),
      .push_front_rdy  (push_front_rdy),
      .push_front_data (push_front_data),
      .pop_front_en    (pop_front_en),
      .pop_front_rdy   (pop_front_rdy),
      .pop_front_data  (pop_front_data),
      .pop_back_en     (pop_back_en),
      .pop_back_rdy    (pop_back_rdy),
      .pop_back_data   (pop_back_data),
      .count           (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs shortly after an edge and let combinational outputs settle.
   task automatic drive(input logic pbe, input logic [Width-1:0] pbd,
                        input logic pfe, input logic [Width-1:0] pfd,
                        input logic pope, input logic popb);
      push_back_en    = pbe;
      push_back_data  = pbd;
      push_front_en   = pfe;
      push_front_data = pfd;
      pop_front_en    = pope;
      pop_back_en     = popb;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic push_back(input logic [Width-1:0] d);
      drive(1'b1, d, 1'b0, '0, 1'b0, 1'b0);
      tick();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();
      // Ready outputs held low during reset.
      check("rst_push_front_rdy", 32'(push_front_rdy), 32'd0);
      check("rst_pop_front_rdy",  32'(pop_front_rdy),  32'd0);
      rst = 1'b0;
      #1;
      check("init_count",          32'(count),          32'd0);
      check("init_push_front_rdy", 32'(push_front_rdy), 32'd1);
      check("init_push_back_rdy",  32'(push_back_rdy),  32'd1);
      check("init_pop_front_rdy",  32'(pop_front_rdy),  32'd0);
      check("init_pop_front_data", 32'(pop_front_data), 32'd0);
      check("init_pop_back_data",  32'(pop_back_data),  32'd0);

      // 1: FIFO order through push_back / pop_front.
      push_back(8'h0A);
      push_back(8'h0B);
      push_back(8'h0C);
      check("t1_count", 32'(count),          32'd3);
      check("t1_front", 32'(pop_front_data), 32'h0A);
      check("t1_back",  32'(pop_back_data),  32'h0C);
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check("t1_pop0", 32'(pop_front_data), 32'h0A);
      tick();
      check("t1_pop1", 32'(pop_front_data), 32'h0B);
      tick();
      check("t1_pop2", 32'(pop_front_data), 32'h0C);
      tick();
      idle();
      check("t1_count_end", 32'(count),         32'd0);
      check("t1_pop_rdy_end", 32'(pop_front_rdy), 32'd0);

      // 2: stack order through push_front / pop_front.
      for (int v = 1; v <= 3; v++) begin
         drive(1'b0, '0, 1'b1, Width'(v), 1'b0, 1'b0);
         tick();
      end
      idle();
      check("t2_count", 32'(count), 32'd3);
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check("t2_pop0", 32'(pop_front_data), 32'd3);
      tick();
      check("t2_pop1", 32'(pop_front_data), 32'd2);
      tick();
      check("t2_pop2", 32'(pop_front_data), 32'd1);
      tick();
      idle();
      check("t2_pop_rdy_end", 32'(pop_front_rdy), 32'd0);

      // 3: full boundary.
      for (int v = 0; v < Depth; v++) push_back(Width'(v));
      check("t3_count_full",  32'(count),          32'(Depth));
      check("t3_pb_rdy_full", 32'(push_back_rdy),  32'd0);
      check("t3_pf_rdy_full", 32'(push_front_rdy), 32'd0);
      check("t3_back_full",   32'(pop_back_data),  32'(Depth - 1));
      drive(1'b1, 8'h77, 1'b0, '0, 1'b1, 1'b0);
      check("t3_pop_rdy",   32'(pop_front_rdy),  32'd1);
      check("t3_pop_data",  32'(pop_front_data), 32'd0);
      tick();
      idle();
      check("t3_count_after", 32'(count),          32'(Depth - 1));
      check("t3_front_after", 32'(pop_front_data), 32'd1);
      check("t3_back_after",  32'(pop_back_data),  32'(Depth - 1));
      push_back(8'h55);
      check("t3_back_55",  32'(pop_back_data), 32'h55);
      check("t3_count_55", 32'(count),         32'(Depth));

      // 4: push_front + pop_back on [5,6,7].
      do_reset();
      push_back(8'd5);
      push_back(8'd6);
      push_back(8'd7);
      drive(1'b0, '0, 1'b1, 8'd9, 1'b0, 1'b1);
      check("t4_pb_rdy",    32'(pop_back_rdy),  32'd1);
      check("t4_pop_back",  32'(pop_back_data), 32'd7);
      tick();
      idle();
      check("t4_count", 32'(count),          32'd3);
      check("t4_front", 32'(pop_front_data), 32'd9);
      check("t4_back",  32'(pop_back_data),  32'd6);
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      tick();
      check("t4_mid", 32'(pop_front_data), 32'd5);
      idle();

      // 5: both pushes and both pops requested on [4,8].
      do_reset();
      push_back(8'd4);
      push_back(8'd8);
      drive(1'b1, 8'd2, 1'b1, 8'd1, 1'b1, 1'b1);
      check("t5_pb_rdy",  32'(push_back_rdy),  32'd0);
      check("t5_popb_rdy", 32'(pop_back_rdy),  32'd0);
      check("t5_pf_rdy",  32'(push_front_rdy), 32'd1);
      check("t5_pop_data", 32'(pop_front_data), 32'd4);
      tick();
      idle();
      check("t5_count", 32'(count),          32'd2);
      check("t5_front", 32'(pop_front_data), 32'd1);
      check("t5_back",  32'(pop_back_data),  32'd8);

      // Single-entry replace-tail, then push_back + pop_front shift.
      do_reset();
      push_back(8'h11);
      drive(1'b1, 8'h22, 1'b0, '0, 1'b0, 1'b1);
      check("s1_pop_back", 32'(pop_back_data), 32'h11);
      tick();
      idle();
      check("s1_count", 32'(count),          32'd1);
      check("s1_front", 32'(pop_front_data), 32'h22);
      push_back(8'h33);
      drive(1'b1, 8'h44, 1'b0, '0, 1'b1, 1'b0);
      check("s2_pop_front", 32'(pop_front_data), 32'h22);
      tick();
      idle();
      check("s2_count", 32'(count),          32'd2);
      check("s2_front", 32'(pop_front_data), 32'h33);
      check("s2_back",  32'(pop_back_data),  32'h44);
      // Single entry: push_front + pop_front replaces the head.
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b1, 8'h66, 1'b1, 1'b0);
      check("s3_pop_front", 32'(pop_front_data), 32'h33);
      tick();
      idle();
      check("s3_count", 32'(count),          32'd1);
      check("s3_front", 32'(pop_front_data), 32'h66);

      // 6: reset with a pop pending on a full deque.
      push_back(8'd1);
      push_back(8'd2);
      push_back(8'd3);
      check("t6_count_pre", 32'(count), 32'd4);
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check("t6_pop_rdy_rst", 32'(pop_front_rdy), 32'd0);
      tick();
      rst = 1'b0;
      idle();
      check("t6_count",      32'(count),          32'd0);
      check("t6_popf_rdy",   32'(pop_front_rdy),  32'd0);
      check("t6_popb_rdy",   32'(pop_back_rdy),   32'd0);
      check("t6_pushf_rdy",  32'(push_front_rdy), 32'd1);
      check("t6_pushb_rdy",  32'(push_back_rdy),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
